// File: rtl/multicycle_control_if.sv
// Control-to-datapath bundle for the multi-cycle MIPS controller.
// master = controller side, slave = datapath / IR / memory side.
interface multicycle_control_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      instruction;
    logic             zero;
    logic             mem_ready;

    logic             pc_en;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_source;
    logic             illegal_op;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;

    modport master (
        input  instruction, zero, mem_ready,
        output pc_en, i_or_d, mem_read, mem_write, ir_write,
        output mem_to_reg, reg_dst, reg_write, alu_src_a,
        output alu_src_b, alu_op, pc_source, illegal_op,
        output state, retired
    );

    modport slave (
        output instruction, zero, mem_ready,
        input  pc_en, i_or_d, mem_read, mem_write, ir_write,
        input  mem_to_reg, reg_dst, reg_write, alu_src_a,
        input  alu_src_b, alu_op, pc_source, illegal_op,
        input  state, retired
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: registered Moore selects/enables plus
// Mealy gating of pc_en/ir_write on mem_ready and the branch condition.
module multicycle_control #(
    parameter int CNT_W     = 16,
    parameter int EN_ADDI   = 1,
    parameter int EN_BNE    = 1,
    parameter int TRAP_HALT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12,
        S_TRAP      = 4'd13
    } state_e;

    typedef struct packed {
        logic       pc_en;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctl_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    state_e           state_q;
    state_e           state_d;
    state_e           dispatch;
    ctl_t             ctl_q;
    logic             bne_q;
    logic [CNT_W-1:0] retired_q;
    logic [5:0]       opcode;
    logic             fetch_go;
    logic             in_branch;
    logic             retire;
    logic             unused_instr;

    assign opcode       = bus.instruction[31:26];
    assign unused_instr = ^bus.instruction[25:0];

    // Moore part of the outputs, evaluated for the state being entered
    function automatic ctl_t moore(state_e s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b01;
                c.pc_source = 2'b01;
            end
            S_JUMP: begin
                c.pc_source = 2'b10;
                c.pc_en     = 1'b1;
            end
            S_ADDI_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_ADDI_WB: begin
                c.reg_write = 1'b1;
            end
            S_TRAP: begin
                c.illegal_op = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        dispatch = S_TRAP;
        unique case (1'b1)
            opcode == OP_R:
                dispatch = S_R_EXEC;
            opcode == OP_LW,
            opcode == OP_SW:
                dispatch = S_MEM_ADDR;
            opcode == OP_BEQ:
                dispatch = S_BRANCH;
            opcode == OP_BNE && EN_BNE != 0:
                dispatch = S_BRANCH;
            opcode == OP_J:
                dispatch = S_JUMP;
            opcode == OP_ADDI && EN_ADDI != 0:
                dispatch = S_ADDI_EXEC;
            default:
                dispatch = S_TRAP;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      state_d = S_FETCH;
            S_FETCH:     if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE:    state_d = dispatch;
            S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ
                                                     : S_MEM_WRITE;
            S_MEM_READ:  if (bus.mem_ready) state_d = S_MEM_WB;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: if (bus.mem_ready) state_d = S_FETCH;
            S_R_EXEC:    state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
            S_TRAP:      state_d = (TRAP_HALT != 0) ? S_TRAP : S_FETCH;
            default:     state_d = S_IDLE;
        endcase
    end

    // An instruction retires on the edge that leaves its last state
    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_MEM_WB,
            S_R_WB,
            S_ADDI_WB,
            S_BRANCH,
            S_JUMP:      retire = 1'b1;
            S_MEM_WRITE: retire = bus.mem_ready;
            default:     retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ctl_q     <= '0;
            bne_q     <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            ctl_q   <= moore(state_d);
            if (state_q == S_DECODE) begin
                bne_q <= (opcode == OP_BNE);
            end
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign fetch_go  = (state_q == S_FETCH) & bus.mem_ready;
    assign in_branch = (state_q == S_BRANCH);

    assign bus.pc_en      = ctl_q.pc_en | fetch_go
                          | (in_branch & (bus.zero ^ bne_q));
    assign bus.ir_write   = fetch_go;
    assign bus.i_or_d     = ctl_q.i_or_d;
    assign bus.mem_read   = ctl_q.mem_read;
    assign bus.mem_write  = ctl_q.mem_write;
    assign bus.mem_to_reg = ctl_q.mem_to_reg;
    assign bus.reg_dst    = ctl_q.reg_dst;
    assign bus.reg_write  = ctl_q.reg_write;
    assign bus.alu_src_a  = ctl_q.alu_src_a;
    assign bus.alu_src_b  = ctl_q.alu_src_b;
    assign bus.alu_op     = ctl_q.alu_op;
    assign bus.pc_source  = ctl_q.pc_source;
    assign bus.illegal_op = ctl_q.illegal_op;
    assign bus.state      = state_q;
    assign bus.retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: two parameterisations,
// directed per-cycle vectors, monitor pops expectations on each negedge.
module tb_multicycle_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    multicycle_control_if #(.CNT_W(16)) ia();
    multicycle_control_if #(.CNT_W(4))  ib();

    multicycle_control #(
        .CNT_W(16), .EN_ADDI(1), .EN_BNE(1), .TRAP_HALT(1)
    ) dut_a (
        .clk(clk), .reset(rst_a), .bus(ia)
    );

    multicycle_control #(
        .CNT_W(4), .EN_ADDI(0), .EN_BNE(1), .TRAP_HALT(0)
    ) dut_b (
        .clk(clk), .reset(rst_b), .bus(ib)
    );

    localparam logic [3:0] S_IDLE = 4'd0, S_F = 4'd1, S_D = 4'd2;
    localparam logic [3:0] S_MA = 4'd3, S_MR = 4'd4, S_MWB = 4'd5;
    localparam logic [3:0] S_MW = 4'd6, S_RX = 4'd7, S_RWB = 4'd8;
    localparam logic [3:0] S_BR = 4'd9, S_J = 4'd10, S_AX = 4'd11;
    localparam logic [3:0] S_AWB = 4'd12, S_TRAP = 4'd13;

    localparam logic [5:0] R = 6'h00, LW = 6'h23, SW = 6'h2B;
    localparam logic [5:0] BEQ = 6'h04, BNE = 6'h05, J = 6'h02;
    localparam logic [5:0] ADDI = 6'h08, BAD = 6'h3F;

    typedef struct packed {
        logic       pc_en;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctl_t;

    typedef struct {
        logic [3:0]  st;
        ctl_t        c;
        logic [15:0] ret;
        int          row;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;
    int   row = 0;
    logic bne_x[2];

    ctl_t act_a, act_b;
    assign act_a = {ia.pc_en, ia.i_or_d, ia.mem_read, ia.mem_write,
                    ia.ir_write, ia.mem_to_reg, ia.reg_dst, ia.reg_write,
                    ia.alu_src_a, ia.alu_src_b, ia.alu_op, ia.pc_source,
                    ia.illegal_op};
    assign act_b = {ib.pc_en, ib.i_or_d, ib.mem_read, ib.mem_write,
                    ib.ir_write, ib.mem_to_reg, ib.reg_dst, ib.reg_write,
                    ib.alu_src_a, ib.alu_src_b, ib.alu_op, ib.pc_source,
                    ib.illegal_op};

    // Expected control word per state, straight from the state table
    function automatic ctl_t ctl_of(logic [3:0] st, logic mr,
                                    logic z, logic bne);
        ctl_t c;
        c = '0;
        case (st)
            S_F: begin
                c.mem_read = 1; c.alu_src_b = 2'b01;
                c.ir_write = mr; c.pc_en = mr;
            end
            S_D:   c.alu_src_b = 2'b11;
            S_MA:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            S_MR:  begin c.mem_read = 1; c.i_or_d = 1; end
            S_MWB: begin c.reg_write = 1; c.mem_to_reg = 1; end
            S_MW:  begin c.mem_write = 1; c.i_or_d = 1; end
            S_RX:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            S_RWB: begin c.reg_write = 1; c.reg_dst = 1; end
            S_BR: begin
                c.alu_src_a = 1; c.alu_op = 2'b01;
                c.pc_source = 2'b01; c.pc_en = z ^ bne;
            end
            S_J:   begin c.pc_source = 2'b10; c.pc_en = 1; end
            S_AX:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            S_AWB: c.reg_write = 1;
            S_TRAP: c.illegal_op = 1;
            default: c = '0;
        endcase
        return c;
    endfunction

    task automatic v(input int b, input logic r, input logic [5:0] op,
                     input logic z, input logic mr,
                     input logic [3:0] st, input int ret);
        exp_t e;
        @(posedge clk);
        #1;
        if (b == 0) begin
            rst_a = r;
            ia.instruction = {op, 26'h0ABCDE};
            ia.zero = z;
            ia.mem_ready = mr;
        end else begin
            rst_b = r;
            ib.instruction = {op, 26'h0ABCDE};
            ib.zero = z;
            ib.mem_ready = mr;
        end
        if (st == S_D) bne_x[b] = (op == BNE);
        e.st  = st;
        e.c   = ctl_of(st, mr, z, bne_x[b]);
        e.ret = 16'(ret);
        e.row = row;
        row++;
        if (b == 0) qa.push_back(e);
        else qb.push_back(e);
    endtask

    task automatic chk(input int b, input exp_t e, input logic [3:0] st,
                       input ctl_t c, input logic [15:0] ret);
        checks++;
        if (st !== e.st || c !== e.c || ret !== e.ret) begin
            errors++;
            $display("FAIL dut%0d row%0d: got state=%0d ctl=%h ret=%0d, expected state=%0d ctl=%h ret=%0d",
                     b, e.row, st, c, ret, e.st, e.c, e.ret);
        end
        checks++;
        if ((c.mem_read && c.mem_write) || (c.reg_write && c.mem_write)) begin
            errors++;
            $display("FAIL dut%0d row%0d exclusive enables: ctl=%h, expected no overlap",
                     b, e.row, c);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (qa.size() != 0) begin
            e = qa.pop_front();
            chk(0, e, ia.state, act_a, ia.retired);
        end
        if (qb.size() != 0) begin
            e = qb.pop_front();
            chk(1, e, ib.state, act_b, {12'h000, ib.retired});
        end
    end

    initial begin
        ia.instruction = '0; ia.zero = 0; ia.mem_ready = 0;
        ib.instruction = '0; ib.zero = 0; ib.mem_ready = 0;
        bne_x[0] = 0;
        bne_x[1] = 0;

        // DUT A: reset, then R-type
        v(0, 1, R, 0, 1, S_IDLE, 0);
        v(0, 1, R, 0, 1, S_IDLE, 0);
        v(0, 0, R, 0, 1, S_IDLE, 0);
        v(0, 0, R, 0, 1, S_F, 0);
        v(0, 0, R, 0, 1, S_D, 0);
        v(0, 0, R, 0, 1, S_RX, 0);
        v(0, 0, R, 0, 1, S_RWB, 0);
        // lw with two stall cycles in MEM_READ
        v(0, 0, LW, 0, 1, S_F, 1);
        v(0, 0, LW, 0, 1, S_D, 1);
        v(0, 0, LW, 0, 1, S_MA, 1);
        v(0, 0, LW, 0, 0, S_MR, 1);
        v(0, 0, LW, 0, 0, S_MR, 1);
        v(0, 0, LW, 0, 1, S_MR, 1);
        v(0, 0, LW, 0, 1, S_MWB, 1);
        // sw with one fetch stall and one write stall
        v(0, 0, SW, 0, 0, S_F, 2);
        v(0, 0, SW, 0, 1, S_F, 2);
        v(0, 0, SW, 0, 1, S_D, 2);
        v(0, 0, SW, 0, 1, S_MA, 2);
        v(0, 0, SW, 0, 0, S_MW, 2);
        v(0, 0, SW, 0, 1, S_MW, 2);
        // beq taken, bne not taken, bne taken
        v(0, 0, BEQ, 0, 1, S_F, 3);
        v(0, 0, BEQ, 0, 1, S_D, 3);
        v(0, 0, BEQ, 1, 1, S_BR, 3);
        v(0, 0, BNE, 0, 1, S_F, 4);
        v(0, 0, BNE, 0, 1, S_D, 4);
        v(0, 0, BNE, 1, 1, S_BR, 4);
        v(0, 0, BNE, 0, 1, S_F, 5);
        v(0, 0, BNE, 0, 1, S_D, 5);
        v(0, 0, BNE, 0, 1, S_BR, 5);
        // j, addi
        v(0, 0, J, 0, 1, S_F, 6);
        v(0, 0, J, 0, 1, S_D, 6);
        v(0, 0, J, 0, 1, S_J, 6);
        v(0, 0, ADDI, 0, 1, S_F, 7);
        v(0, 0, ADDI, 0, 1, S_D, 7);
        v(0, 0, ADDI, 0, 1, S_AX, 7);
        v(0, 0, ADDI, 0, 1, S_AWB, 7);
        // sw interrupted by reset while waiting in MEM_WRITE
        v(0, 0, SW, 0, 1, S_F, 8);
        v(0, 0, SW, 0, 1, S_D, 8);
        v(0, 0, SW, 0, 1, S_MA, 8);
        v(0, 0, SW, 0, 0, S_MW, 8);
        v(0, 1, SW, 0, 1, S_IDLE, 0);
        v(0, 0, J, 0, 1, S_IDLE, 0);
        v(0, 0, J, 0, 1, S_F, 0);
        v(0, 0, J, 0, 1, S_D, 0);
        v(0, 0, J, 0, 1, S_J, 0);
        // illegal opcode, halting trap
        v(0, 0, BAD, 0, 1, S_F, 1);
        v(0, 0, BAD, 0, 1, S_D, 1);
        for (int i = 0; i < 10; i++) v(0, 0, BAD, 0, 1, S_TRAP, 1);

        // DUT B: addi disabled, non-halting trap, 4-bit counter
        v(1, 1, J, 0, 1, S_IDLE, 0);
        v(1, 0, J, 0, 1, S_IDLE, 0);
        v(1, 0, ADDI, 0, 1, S_F, 0);
        v(1, 0, ADDI, 0, 1, S_D, 0);
        v(1, 0, ADDI, 0, 1, S_TRAP, 0);
        v(1, 0, BAD, 0, 1, S_F, 0);
        v(1, 0, BAD, 0, 1, S_D, 0);
        v(1, 0, BAD, 0, 1, S_TRAP, 0);
        for (int k = 0; k < 16; k++) begin
            v(1, 0, J, 0, 1, S_F, k);
            v(1, 0, J, 0, 1, S_D, k);
            v(1, 0, J, 0, 1, S_J, k);
        end
        v(1, 0, J, 0, 1, S_F, 0);

        repeat (3) @(posedge clk);
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain: pending a=%0d b=%0d, expected 0 0",
                     qa.size(), qb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
